// File: rtl/riscv_mem_pkg.sv
// Shared store-path types and funct3 encodings for the store write buffer.
// The entry struct is sized by WB_ADDR_W; the buffer's ADDR_W must match it.
package riscv_mem_pkg;

  localparam int unsigned WB_ADDR_W = 32;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           strb;
  } wb_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store lane alignment: replicates data across byte lanes and
// builds byte strobes from funct3 and the low address bits.
module store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data_in,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        legal
);

  always_comb begin
    wdata = '0;
    wstrb = '0;
    legal = 1'b0;
    case (funct3)
      F3_SB: begin
        wdata = {4{data_in[7:0]}};
        wstrb = 4'b0001 << off;
        legal = 1'b1;
      end
      F3_SH: begin
        wdata = {2{data_in[15:0]}};
        wstrb = 4'b0011 << off;
        legal = ~off[0];
      end
      F3_SW: begin
        wdata = data_in;
        wstrb = 4'b1111;
        legal = (off == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// In-order store write buffer between MEM stage and the D-cache write port.
// Optional load-hazard address compare is built when WB_LOAD_HAZARD_EN is defined.
module store_write_buffer
  import riscv_mem_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_funct3,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              misalign,
  output logic              empty,
  output logic [CW-1:0]     count
`ifdef WB_LOAD_HAZARD_EN
  ,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic        al_legal;

  store_align u_align (
    .funct3  (st_funct3),
    .off     (st_addr[1:0]),
    .data_in (st_data),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb),
    .legal   (al_legal)
  );

  wb_entry_t         entries_q [DEPTH];
  wb_entry_t         entries_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              misalign_q, misalign_d;
  logic              accept, push, pop;
  wb_entry_t         new_entry;
  wb_entry_t         head;

  assign st_ready   = (count_q < CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign mem_wvalid = ~empty;
  assign count      = count_q;
  assign misalign   = misalign_q;

  assign accept = st_valid & st_ready;
  assign push   = accept & al_legal;
  assign pop    = mem_wvalid & mem_wready;

  // Word-aligned address; sub-word position lives entirely in the strobes.
  assign new_entry.addr = WB_ADDR_W'({st_addr[ADDR_W-1:2], 2'b00});
  assign new_entry.data = al_wdata;
  assign new_entry.strb = al_wstrb;

  // Storage is cleared on reset, so the head reads as zero while empty after reset.
  assign head      = entries_q[rd_ptr_q];
  assign mem_waddr = ADDR_W'(head.addr);
  assign mem_wdata = head.data;
  assign mem_wstrb = head.strb;

  always_comb begin
    entries_d  = entries_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    misalign_d = accept & ~al_legal;
    if (push) begin
      entries_d[wr_ptr_q] = new_entry;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef WB_LOAD_HAZARD_EN
  logic [ADDR_W-1:0] ld_word;
  assign ld_word = ld_addr & ~ADDR_W'(3);

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - rd_ptr_q)) < count_q) &&
          (ADDR_W'(entries_q[i].addr) == ld_word))
        ld_conflict = 1'b1;
    end
  end
`endif

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
Store-side counterpart of the writeback result path. It accepts store requests from the MEM stage, aligns the data and generates byte strobes for SB/SH/SW, and queues them in a small in-order FIFO. It then drains them to the data cache/memory write port over a valid/ready handshake. It sits between the core's MEM stage and the D-cache write interface.

Parameters:
DEPTH, 4, number of buffered stores; power of 2, at least 2.
ADDR_W, 32, byte address width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous reset, active-low.
st_valid  input  1  store request valid.
st_ready  output  1  buffer can accept a request; equals count < DEPTH.
st_addr  input  ADDR_W  byte address of store.
st_data  input  32  rs2 value, unaligned (low bits significant).
st_funct3  input  3  000 = SB, 001 = SH, 010 = SW; other codes are illegal.
mem_wvalid  output  1  head entry valid toward memory.
mem_wready  input  1  memory accepts head entry.
mem_waddr  output  ADDR_W  word-aligned address {st_addr[ADDR_W-1:2], 2'b00}.
mem_wdata  output  32  lane-replicated store data.
mem_wstrb  output  4  byte enables.
misalign  output  1  one-cycle pulse: a rejected misaligned or illegal request.
empty  output  1  no entries buffered.
count  output  $clog2(DEPTH+1)  number of entries buffered.

Behaviour:
- Reset: while rst_n is low, count, read/write pointers, misalign and all storage entries are cleared asynchronously. mem_wvalid = 0, mem_waddr/mem_wdata/mem_wstrb = 0, empty = 1, st_ready = 1.
- Accept: the handshake completes on st_valid && st_ready at a rising edge.
- Alignment, with off = st_addr[1:0]:
  - SB: wdata = {4{st_data[7:0]}}, wstrb = 4'b0001 << off.
  - SH: legal only if off[0] = 0. wdata = {2{st_data[15:0]}}, wstrb = 4'b0011 << off.
  - SW: legal only if off = 0. wdata = st_data, wstrb = 4'b1111.
- Rejection: a misaligned or illegal-funct3 request still completes its handshake but is NOT enqueued. misalign is high for exactly the next cycle and count is unchanged.
- Latency: an entry accepted at edge N is on mem_w* with mem_wvalid = 1 after edge N when the buffer was empty. Otherwise it appears after all older entries drain. Strict FIFO order, no merging.
- Drain: mem_wvalid = !empty. The head pops on mem_wvalid && mem_wready. While mem_wvalid is high and mem_wready is low, mem_waddr, mem_wdata and mem_wstrb hold stable.
- Simultaneous push and pop:
  - Allowed whenever count < DEPTH; count is unchanged.
  - When full, st_ready = 0, so no push is possible even if a pop occurs that cycle (no same-cycle bypass).
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Reset mid-operation: all buffered stores are discarded immediately, and mem_wvalid drops asynchronously with rst_n.

Optional Feature:
Macro WB_LOAD_HAZARD_EN.
- With it defined: adds input ld_addr (ADDR_W) and output ld_conflict (1). ld_conflict is combinational. It is 1 when any valid entry's word address equals {ld_addr[ADDR_W-1:2], 2'b00}. The core stalls the load until ld_conflict = 0.
- Without it: neither port exists, and no comparators are built.

Decomposition:
- Package riscv_mem_pkg holds:
  - constants F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010;
  - typedef wb_entry_t as a packed struct {addr[ADDR_W-1:0], data[31:0], strb[3:0]}.
- Sub-module store_align: purely combinational funct3/offset to data/strb/legal; instantiated once.
- FIFO storage and control stay in store_write_buffer.

Test Plan:
1. mem_wready = 1; SW addr 0x100, data 0xDEADBEEF -> next cycle mem_wvalid = 1, waddr 0x100, wdata 0xDEADBEEF, wstrb 4'b1111; empty = 1 after pop.
2. SB addr 0x103, data 0x000000AB -> waddr 0x100, wdata 0xABABABAB, wstrb 4'b1000.
3. SH addr 0x202, data 0x1234 -> wdata 0x12341234, wstrb 4'b1100. Then SH addr 0x201 -> misalign pulses one cycle, count unchanged. SW addr 0x102 and funct3 = 3'b011 -> also rejected.
4. mem_wready = 0; push 4 SWs (0x0, 0x4, 0x8, 0xC) -> count = 4, st_ready = 0, head stable. Raise mem_wready -> drained in order over 4 cycles, then empty = 1.
5. count = 2, push and pop on the same edge -> count stays 2, order preserved across pointer wrap. With WB_LOAD_HAZARD_EN: ld_addr 0x6 while 0x4 is buffered -> ld_conflict = 1.
6. count = 3 with mem_wready = 0; assert rst_n low mid-cycle -> mem_wvalid = 0 and count = 0 before the next edge; after release, empty = 1 and st_ready = 1.
